// File: rtl/sha512_pkg.sv
// rtl/sha512_pkg.sv - shared constants and state encoding for the SHA-512 de-padder
package sha512_pkg;
  localparam int WORD_W      = 64;
  localparam int BLOCK_WORDS = 16;
  localparam int HOLD_WORDS  = 18;
  localparam int LEN_FIELD_W = 128;

  typedef enum logic [1:0] {STREAM, PARSE, DRAIN, DONE} state_t;
endpackage

// File: rtl/sha512_hold_buf.sv
// rtl/sha512_hold_buf.sv - circular hold-back buffer; full rotated view only with SHA512_DEPAD_PAD_CHECK_EN
module sha512_hold_buf
  import sha512_pkg::*;
#(
  parameter int DEPTH = HOLD_WORDS,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] head,
  output logic [WORD_W-1:0] tail1,
  output logic [WORD_W-1:0] tail2,
  output logic [OCC_W-1:0]  occ
`ifdef SHA512_DEPAD_PAD_CHECK_EN
  ,
  output logic [DEPTH*WORD_W-1:0] all_q
`endif
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A simultaneous push and pop on a full buffer reads the old head before the slot is rewritten.
  assign head  = mem[rd_ptr];
  assign tail1 = mem[(wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - PTR_W'(1)];
  assign tail2 = mem[(wr_ptr < PTR_W'(2)) ? wr_ptr + PTR_W'(DEPTH - 2) : wr_ptr - PTR_W'(2)];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef SHA512_DEPAD_PAD_CHECK_EN
  // Oldest word in slot 0.
  always_comb begin
    all_q = '0;
    for (int k = 0; k < DEPTH; k++) begin
      int idx;
      idx = int'(rd_ptr) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      all_q[k*WORD_W +: WORD_W] = mem[PTR_W'(idx)];
    end
  end
`endif
endmodule

// File: rtl/sha512_depad.sv
// rtl/sha512_depad.sv - strips SHA-512 padding and re-emits the message; SHA512_DEPAD_PAD_CHECK_EN adds pad-content check
module sha512_depad
  import sha512_pkg::*;
#(
  parameter int LEN_W = 64,
  parameter int CNT_W = 32,
  parameter int HOLD  = HOLD_WORDS
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [6:0]  m_bits,
  output logic        done,
  output logic        err
);
  localparam int OCC_W   = $clog2(HOLD + 1);
  localparam int AW      = LEN_W + CNT_W + 8;
  localparam int BLK_LOG = $clog2(BLOCK_WORDS);

  state_t            state;
  logic              run;
  logic [CNT_W-1:0]  n;
  logic              ovf;
  logic [OCC_W-1:0]  drain_cnt;
  logic [6:0]        last_bits;

  logic [WORD_W-1:0] head, tail1, tail2;
  logic [OCC_W-1:0]  occ;
  logic              full, s_fire, push, pop, clr;

  logic [LEN_FIELD_W-1:0] len128;
  logic [LEN_W-1:0]       len_l;
  logic [AW-1:0]          l_w, n64, e64, r_bits;
  logic                   len_hi_bad, c_blk, c_short, c_long, c_early, pad_bad, bad;

  assign full    = (occ == OCC_W'(HOLD));
  assign s_ready = run && (state == STREAM) && (!full || m_ready);
  assign s_fire  = s_valid && s_ready;
  assign push    = s_fire;
  assign pop     = ((state == STREAM) && full && s_fire) || ((state == DRAIN) && m_ready);
  assign clr     = (state == DONE);

`ifdef SHA512_DEPAD_PAD_CHECK_EN
  logic [HOLD*WORD_W-1:0] all_q;
`endif

  sha512_hold_buf #(.DEPTH(HOLD)) u_buf (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .head  (head),
    .tail1 (tail1),
    .tail2 (tail2),
    .occ   (occ)
`ifdef SHA512_DEPAD_PAD_CHECK_EN
    ,
    .all_q (all_q)
`endif
  );

  // Length field occupies the last two buffered words; R counts message bits still buffered.
  assign len128     = {tail2, tail1};
  assign len_l      = len128[LEN_W-1:0];
  assign len_hi_bad = |(len128 >> LEN_W);
  assign l_w        = AW'(len_l);
  assign n64        = AW'(n) << 6;
  assign e64        = AW'(n - CNT_W'(occ)) << 6;
  assign r_bits     = l_w - e64;
  assign c_blk      = (n[BLK_LOG-1:0] != '0);
  assign c_short    = (l_w + AW'(129)) > n64;
  assign c_long     = !c_short && ((n64 - l_w - AW'(129)) >= AW'(1024));
  assign c_early    = l_w < e64;
  assign bad        = ovf | c_blk | len_hi_bad | c_short | c_long | c_early | pad_bad;

`ifdef SHA512_DEPAD_PAD_CHECK_EN
  // Bit R of the buffered message must be the 1 marker; everything after it up to the length field is 0.
  always_comb begin
    pad_bad = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      if (k + 2 < int'(occ)) begin
        for (int b = 0; b < WORD_W; b++) begin
          if ((AW'(k*WORD_W + b) == r_bits) && !all_q[k*WORD_W + (WORD_W-1-b)]) pad_bad = 1'b1;
          if ((AW'(k*WORD_W + b) >  r_bits) &&  all_q[k*WORD_W + (WORD_W-1-b)]) pad_bad = 1'b1;
        end
      end
    end
  end
`else
  assign pad_bad = 1'b0;
`endif

  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    m_bits  = '0;
    if ((state == STREAM) && full && s_valid) begin
      m_valid = 1'b1;
      m_data  = head;
      m_bits  = 7'd64;
    end else if (state == DRAIN) begin
      m_valid = 1'b1;
      m_last  = (drain_cnt == OCC_W'(1));
      m_bits  = m_last ? last_bits : 7'd64;
      m_data  = head & ({WORD_W{1'b1}} << (7'd64 - m_bits));
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state     <= STREAM;
      run       <= 1'b0;
      n         <= '0;
      ovf       <= 1'b0;
      drain_cnt <= '0;
      last_bits <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      run  <= 1'b1;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        STREAM: begin
          if (s_fire) begin
            n <= n + CNT_W'(1);
            if (&n) ovf <= 1'b1;
            if (s_last) state <= PARSE;
          end
        end
        PARSE: begin
          if (bad) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (r_bits == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= OCC_W'((r_bits + AW'(63)) >> 6);
            last_bits <= (r_bits[5:0] == 6'd0) ? 7'd64 : {1'b0, r_bits[5:0]};
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            drain_cnt <= drain_cnt - OCC_W'(1);
            if (drain_cnt == OCC_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          n     <= '0;
          ovf   <= 1'b0;
          state <= STREAM;
        end
        default: state <= STREAM;
      endcase
    end
  end
endmodule

// File: tb/tb_sha512_depad.sv
// tb/tb_sha512_depad.sv - directed self-checking bench for sha512_depad
module tb_sha512_depad;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [63:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [63:0] m_data;
  logic        m_valid, m_ready, m_last;
  logic [6:0]  m_bits;
  logic        done, err;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  logic done_err = 1'b0;
  int prev;

  logic [63:0] oq_data[$];
  logic [6:0]  oq_bits[$];
  logic        oq_last[$];
  logic [63:0] msg[$];

  always #5 clk = ~clk;

  sha512_depad dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .m_bits  (m_bits),
    .done    (done),
    .err     (err)
  );

  always @(posedge clk) begin
    if (m_valid && m_ready) begin
      oq_data.push_back(m_data);
      oq_bits.push_back(m_bits);
      oq_last.push_back(m_last);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_err <= err;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx, input logic [63:0] d,
                         input logic [6:0] b, input logic l);
    if (idx < oq_data.size()) begin
      chk({tag, "_data"}, oq_data[idx], d);
      chk({tag, "_bits"}, 64'(oq_bits[idx]), 64'(b));
      chk({tag, "_last"}, 64'(oq_last[idx]), 64'(l));
    end else begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s_missing: observed %0d words expected more than %0d", tag, oq_data.size(), idx);
    end
  endtask

  task automatic clear_out();
    oq_data.delete();
    oq_bits.delete();
    oq_last.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [63:0] d, input logic l);
    int waitc;
    logic rdy;
    s_data = d; s_valid = 1'b1; s_last = l; waitc = 0;
    forever begin
      #1 rdy = s_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
      waitc++;
      if (waitc > 200) begin
        tests_run++;
        tests_failed++;
        $error("FAIL send_timeout: observed no s_ready expected s_ready within 200 cycles");
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_msg();
    for (int i = 0; i < msg.size(); i++) send(msg[i], i == msg.size() - 1);
  endtask

  task automatic wait_done(input string tag, input int p, input logic exp_err);
    int cyc;
    cyc = 0;
    while (done_cnt == p && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_done"}, 64'(done_cnt - p), 64'd1);
    chk({tag, "_err"}, 64'(done_err), 64'(exp_err));
  endtask

  task automatic abc_block(input logic [63:0] w0, input logic [63:0] w14);
    msg.delete();
    msg.push_back(w0);
    repeat (13) msg.push_back(64'h0);
    msg.push_back(w14);
    msg.push_back(64'h18);
  endtask

  task automatic two_block_1024(input logic [63:0] base);
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(base + 64'(i));
    msg.push_back(64'h8000000000000000);
    repeat (14) msg.push_back(64'h0);
    msg.push_back(64'h400);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic exp_pad_err;
    n_rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last",  64'(m_last),  64'd0);
    chk("rst_m_bits",  64'(m_bits),  64'd0);
    chk("rst_m_data",  m_data,       64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_err",     64'(err),     64'd0);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);

    // "abc": one 24-bit word out
    abc_block(64'h6162638000000000, 64'h0);
    clear_out(); prev = done_cnt; send_msg();
    wait_done("abc", prev, 1'b0);
    chk("abc_count", 64'(oq_data.size()), 64'd1);
    chk_out("abc", 0, 64'h6162630000000000, 7'd24, 1'b1);

    // empty message
    msg.delete();
    msg.push_back(64'h8000000000000000);
    repeat (15) msg.push_back(64'h0);
    clear_out(); prev = done_cnt; send_msg();
    wait_done("empty", prev, 1'b0);
    chk("empty_count", 64'(oq_data.size()), 64'd0);

    // 200-bit message: 3 full words + 8-bit tail
    msg.delete();
    msg.push_back(64'h1111111111111111);
    msg.push_back(64'h2222222222222222);
    msg.push_back(64'h3333333333333333);
    msg.push_back(64'hAB80000000000000);
    repeat (11) msg.push_back(64'h0);
    msg.push_back(64'd200);
    clear_out(); prev = done_cnt; send_msg();
    wait_done("l200", prev, 1'b0);
    chk("l200_count", 64'(oq_data.size()), 64'd4);
    chk_out("l200_w0", 0, 64'h1111111111111111, 7'd64, 1'b0);
    chk_out("l200_w2", 2, 64'h3333333333333333, 7'd64, 1'b0);
    chk_out("l200_w3", 3, 64'hAB00000000000000, 7'd8, 1'b1);

    // L=1024 over two blocks: 14 words in STREAM, 2 in DRAIN
    two_block_1024(64'h0123456700000000);
    clear_out(); prev = done_cnt; send_msg();
    chk("l1024_stream_count", 64'(oq_data.size()), 64'd14);
    wait_done("l1024", prev, 1'b0);
    chk("l1024_count", 64'(oq_data.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      chk_out($sformatf("l1024_w%0d", i), i, 64'h0123456700000000 + 64'(i), 7'd64, i == 15);

    // backpressure with a full hold buffer
    two_block_1024(64'hA5A5000000000000);
    clear_out(); prev = done_cnt; m_ready = 1'b0;
    for (int i = 0; i < 18; i++) send(msg[i], 1'b0);
    s_data = msg[18]; s_valid = 1'b1; s_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_s_ready_c%0d", c), 64'(s_ready), 64'd0);
      chk($sformatf("bp_m_valid_c%0d", c), 64'(m_valid), 64'd1);
      chk($sformatf("bp_m_data_c%0d", c), m_data, 64'hA5A5000000000000);
      @(negedge clk);
    end
    chk("bp_none_out", 64'(oq_data.size()), 64'd0);
    m_ready = 1'b1;
    for (int i = 18; i < 32; i++) send(msg[i], i == 31);
    wait_done("bp", prev, 1'b0);
    chk("bp_count", 64'(oq_data.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      chk_out($sformatf("bp_w%0d", i), i, 64'hA5A5000000000000 + 64'(i), 7'd64, i == 15);

    // s_last on word 10
    msg.delete();
    msg.push_back(64'h8000000000000000);
    repeat (9) msg.push_back(64'h0);
    clear_out(); prev = done_cnt; send_msg();
    wait_done("short", prev, 1'b1);
    chk("short_count", 64'(oq_data.size()), 64'd0);

    // declared length 2000 in one block
    msg.delete();
    msg.push_back(64'h8000000000000000);
    repeat (14) msg.push_back(64'h0);
    msg.push_back(64'd2000);
    clear_out(); prev = done_cnt; send_msg();
    wait_done("l2000", prev, 1'b1);
    chk("l2000_count", 64'(oq_data.size()), 64'd0);

    // nonzero upper length bits
    abc_block(64'h6162638000000000, 64'h1);
    clear_out(); prev = done_cnt; send_msg();
    wait_done("lenhi", prev, 1'b1);
    chk("lenhi_count", 64'(oq_data.size()), 64'd0);

    // missing pad marker bit
`ifdef SHA512_DEPAD_PAD_CHECK_EN
    exp_pad_err = 1'b1;
`else
    exp_pad_err = 1'b0;
`endif
    abc_block(64'h6162630000000000, 64'h0);
    clear_out(); prev = done_cnt; send_msg();
    wait_done("nopad", prev, exp_pad_err);
    chk("nopad_count", 64'(oq_data.size()), exp_pad_err ? 64'd0 : 64'd1);
    if (!exp_pad_err) chk_out("nopad", 0, 64'h6162630000000000, 7'd24, 1'b1);

    // reset mid-message discards everything without done
    for (int i = 0; i < 5; i++) send(64'hDEAD000000000000 + 64'(i), 1'b0);
    prev = done_cnt;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - prev), 64'd0);
    abc_block(64'h6162638000000000, 64'h0);
    clear_out(); prev = done_cnt; send_msg();
    wait_done("after_rst", prev, 1'b0);
    chk("after_rst_count", 64'(oq_data.size()), 64'd1);
    chk_out("after_rst", 0, 64'h6162630000000000, 7'd24, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sha512_depad.md
Name: sha512_depad

Overview:
- Inverse of the team's SHA-512 padder. Accepts a padded message as a stream of 64-bit big-endian words (16 words per 1024-bit block).
- Reads the 128-bit length field and validates the padding.
- Re-emits only the original message words, with a final valid-bit count.
- Sits between the padded-message store/link and any consumer needing the raw message; also serves as a self-check companion for the padder.

Parameters:
- LEN_W, 64, width of supported message length in bits; length field bits [127:LEN_W] must be zero.
- CNT_W, 32, width of received-word counter N.
- HOLD, 18, hold-back depth in words. Equals the maximum padding (1+1023+128 = 1152 bits); do not override.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset
- s_data  in  64  padded word, big-endian, word 0 first
- s_valid  in  1  input word valid
- s_last  in  1  marks final word of final block
- s_ready  out  1  input accept
- m_data  out  64  message word; bits beyond m_bits forced to 0
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_last  out  1  last message word
- m_bits  out  7  valid MSB-aligned bits in m_data, 1..64
- done  out  1  one-cycle pulse, message finished
- err  out  1  valid with done; 1 = malformed

Behaviour:
- Reset: n_rst, asynchronous, active-high; clock clk.
- Reset values: s_ready=0, m_valid=0, m_last=0, m_bits=0, m_data=0, done=0, err=0; state=STREAM; N=0; occ=0.
- Reset mid-message: discard buffer and counters; no done.
- Transfers occur on valid&&ready at posedge clk.
- STREAM:
  - s_ready = (occ<HOLD) || m_ready.
  - Each accepted word is pushed to the hold buffer; N increments.
  - When occ==HOLD, m_valid = s_valid and m_data = oldest word, with m_last=0 and m_bits=64. The pop coincides with the push; this is the only combinational s_valid->m_valid path.
  - Words ≥HOLD from the end are guaranteed pure message.
  - An accepted word with s_last=1 moves to PARSE; s_ready=0 outside STREAM.
- PARSE (1 cycle):
  - Length field = last two buffered words; L = its low LEN_W bits.
  - E = N - occ (words already emitted); R = L - 64*E (remaining message bits).
  - err if any of: N%16≠0; length field bits [127:LEN_W] nonzero; L+129 > 64*N; 64*N - L - 129 ≥ 1024; L < 64*E.
  - If err, go to DONE (buffer discarded, no m_last). Else if R==0, go to DONE. Else go to DRAIN.
- DRAIN:
  - Emit ceil(R/64) words oldest-first, m_valid=1, held stable until m_ready.
  - Final word: m_last=1, m_bits = R-64*(ceil(R/64)-1), bits below m_bits zeroed. Non-final words: m_bits=64.
  - After the final handshake, discard remaining pad words and go to DONE.
- DONE: done=1, err per result, for exactly one cycle. Clear N and occ; return to STREAM.
- Empty message (L=0): no m_valid, done with err=0.
- Messages shorter than HOLD words: nothing emitted in STREAM; all emitted in DRAIN.
- Length arithmetic is unsigned, LEN_W+CNT_W safe. N overflow (N reaching 2^CNT_W) sets sticky err, reported at DONE.

Optional Feature:
- Macro SHA512_DEPAD_PAD_CHECK_EN.
- Defined: in PARSE, also verify bit at stream position L is 1 and all bits between L+1 and the length field are 0. Any mismatch sets err. The check covers only buffered words, which is sufficient by the HOLD argument.
- Undefined: only the length/count consistency checks apply; pad content is ignored.

Decomposition:
- Package sha512_pkg: WORD_W=64, BLOCK_WORDS=16, HOLD_WORDS=18, LEN_FIELD_W=128, state enum {STREAM, PARSE, DRAIN, DONE}.
- Sub-module sha512_hold_buf: HOLD-entry circular buffer with push/pop, occ count, random read of entries occ-1/occ-2 for the length field and pad check.

Test Plan:
- "abc": one block, word0=0x6162638000000000, words1-14=0, word15=0x18 -> one output word 0x6162630000000000, m_bits=24, m_last=1; done=1, err=0.
- L=0: word0=0x8000000000000000, others 0 -> no m_valid; done=1, err=0.
- L=1024 (two blocks, block2 word0=0x8000000000000000, word15=0x400) -> 16 words out (14 during STREAM, 2 in DRAIN), last m_bits=64; done, err=0.
- Backpressure with occ==18 and m_ready=0 for 5 cycles -> s_ready=0, m_data stable, no word lost or duplicated.
- s_last on word 10 -> done=1, err=1, no m_last. Separately, one block declaring length 2000 -> err=1.
- With SHA512_DEPAD_PAD_CHECK_EN: "abc" block with word0=0x6162630000000000 (missing 1 bit) -> err=1. Without the macro -> err=0.
